coin_sw_ctrl: RTL and testbench
===============================

COIN_SW_CTRL -- requirements
Module: coin_sw_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 65536, is the number of clk_sys cycles an input must hold stable before its debounced level changes.
REQ-002 Parameter PULSE_CNT, default 600000, is the coin_sw high time in clk_sys cycles (0.0105 s at 57.272 MHz).
REQ-003 Parameter GAP_CNT, default 1145440, is the minimum coin_sw low time between pulses (20 ms).
REQ-004 Parameter QUEUE_MAX, default 3, is the saturation limit of the pending-coin counter.
REQ-005 clk_sys  in  1  system clock, 57.272 MHz; the only clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 coin_raw  in  1  asynchronous coin request, OR of player coin buttons.
REQ-008 start_raw  in  1  asynchronous start request, OR of player start buttons.
REQ-009 credit_light_n  in  1  game credit lamp, low = credit present.
REQ-010 coin_sw  out  1  conditioned coin switch to the game core.
REQ-011 start_game  out  1  debounced start level to the game core.
REQ-012 coin_pending  out  2  current pending-coin count.
REQ-013 busy  out  1  high when the FSM is in PULSE or GAP.

Function
REQ-014 coin_raw and start_raw each pass through a 2-flop synchroniser before debouncing.
REQ-015 Debounce: the debounced level takes the synchronised value once that value has differed from it for DEBOUNCE_CNT consecutive cycles; any reversion restarts the count.
REQ-016 start_game equals the debounced start level; latency is 2 + DEBOUNCE_CNT cycles after start_raw changes.
REQ-017 A coin event is a debounced coin 0->1 transition, one cycle wide.
REQ-018 A coin event with credit_light_n=1 increments coin_pending, saturating at QUEUE_MAX; extra events are dropped.
REQ-019 A coin event with credit_light_n=0 is dropped.
REQ-020 A falling edge of credit_light_n clears coin_pending to 0 in the following cycle, overriding a same-cycle increment.
REQ-021 The FSM has three states: IDLE, PULSE and GAP.
REQ-022 IDLE: coin_sw=0. When coin_pending>0 and credit_light_n=1, the next state is PULSE, coin_pending decrements and the timer clears.
REQ-023 PULSE: coin_sw=1 for exactly PULSE_CNT cycles, then the next state is GAP with the timer cleared.
REQ-024 GAP: coin_sw=0 for exactly GAP_CNT cycles, then the next state is IDLE.
REQ-025 A coin event in the same cycle as the IDLE->PULSE decrement leaves coin_pending unchanged (net +1 -1).
REQ-026 A credit_light_n fall during PULSE does not truncate the pulse; the pulse completes, and the pending count is cleared per REQ-020.
REQ-027 coin_sw is driven from a flop with no combinational path from any input.
REQ-028 The timer width is clog2(max(PULSE_CNT, GAP_CNT)); the timer does not wrap within a state.

Reset
REQ-029 On reset: coin_sw=0, start_game=0, coin_pending=0, busy=0, FSM=IDLE, timers=0, synchronisers and debounced levels=0.
REQ-030 Reset asserted during PULSE drops coin_sw to 0 in the next cycle; after release no pulse resumes.

Structure
REQ-031 The state enum (IDLE/PULSE/GAP) and the default timing constants live in the shared package space_race_pkg.
REQ-032 The block instantiates one sub-module, sync_debounce (2-flop synchroniser plus debounce counter), twice: once for coin and once for start.
REQ-033 The block sits between the hps_io joystick bits and the coin_sw/start_game inputs of space_race_top and replaces the inline coin logic.

Verification (DEBOUNCE_CNT=4, PULSE_CNT=10, GAP_CNT=6, QUEUE_MAX=3)
REQ-034 Single coin: coin_raw high 20 cycles with credit_light_n=1 -> exactly one coin_sw pulse of 10 cycles; coin_pending returns to 0.
REQ-035 Bounce: coin_raw toggled every 2 cycles for 20 cycles, then low -> no coin_sw pulse.
REQ-036 Burst: 5 clean presses in quick succession -> pending saturates at 3 and the game sees 4 pulses total (one issued immediately, three queued), each followed by at least 6 low cycles.
REQ-037 Credit: credit_light_n falls while coin_pending=2 during PULSE -> the current pulse completes in 10 cycles, pending is cleared and no further pulses follow.
REQ-038 Reset: reset asserted on PULSE cycle 5 -> coin_sw=0 next cycle and all outputs at reset values; start_game follows start_raw 6 cycles after release.

Source files
------------

// File: rtl/space_race_pkg.sv
// Shared types and default timing for the Space Race coin/start front end.
package space_race_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } coin_state_e;

  // Defaults assume clk_sys = 57.272 MHz.
  localparam int DEF_DEBOUNCE_CNT = 65536;
  localparam int DEF_PULSE_CNT    = 600000;
  localparam int DEF_GAP_CNT      = 1145440;
  localparam int DEF_QUEUE_MAX    = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/coin_sw_ctrl_if.sv
// Player-button side and game-core side signals of the coin/start controller.
interface coin_sw_ctrl_if;
  logic       coin_raw;
  logic       start_raw;
  logic       credit_light_n;
  logic       coin_sw;
  logic       start_game;
  logic [1:0] coin_pending;
  logic       busy;

  modport master (
    output coin_raw, start_raw, credit_light_n,
    input  coin_sw, start_game, coin_pending, busy
  );

  modport slave (
    input  coin_raw, start_raw, credit_light_n,
    output coin_sw, start_game, coin_pending, busy
  );
endinterface

// File: rtl/sync_debounce.sv
// Two-flop synchroniser plus stability counter: the level follows the input
// only after the synchronised value has disagreed with it for DEBOUNCE_CNT cycles.
module sync_debounce
  import space_race_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic raw_i,
  output logic level_o
);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle of agreement restarts the count from zero.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
endmodule

// File: rtl/coin_sw_ctrl.sv
// Conditions coin/start buttons for the game core: queues coin presses and
// replays each one as a fixed-width coin_sw pulse followed by a minimum gap.
//   state | meaning
//   IDLE  | coin_sw low, waiting for a pending coin while credit lamp is off
//   PULSE | coin_sw high for PULSE_CNT cycles
//   GAP   | coin_sw low for GAP_CNT cycles before the next coin may start
module coin_sw_ctrl
  import space_race_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
  parameter int PULSE_CNT    = DEF_PULSE_CNT,
  parameter int GAP_CNT      = DEF_GAP_CNT,
  parameter int QUEUE_MAX    = DEF_QUEUE_MAX
) (
  input logic           clk_sys,
  input logic           reset,
  coin_sw_ctrl_if.slave io
);
  localparam int TMAX = max_int(PULSE_CNT, GAP_CNT);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CNT - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CNT - 1);
  localparam logic [1:0]    Q_MAX      = 2'(QUEUE_MAX);

  coin_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    pend_q, pend_d;
  logic          coin_sw_q, busy_q;
  logic          credit_q;
  logic          coin_lvl, coin_lvl_q, start_lvl;
  logic          coin_inc, pend_dec, credit_fall;

  sync_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_coin_db (
    .clk_sys (clk_sys),
    .reset   (reset),
    .raw_i   (io.coin_raw),
    .level_o (coin_lvl)
  );

  sync_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_start_db (
    .clk_sys (clk_sys),
    .reset   (reset),
    .raw_i   (io.start_raw),
    .level_o (start_lvl)
  );

  assign credit_fall = credit_q & ~io.credit_light_n;
  assign coin_inc    = coin_lvl & ~coin_lvl_q & io.credit_light_n;

  always_comb begin
    state_d  = state_q;
    timer_d  = '0;
    pend_dec = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if ((pend_q != 2'd0) && io.credit_light_n) begin
          state_d  = ST_PULSE;
          pend_dec = 1'b1;
        end
      end
      ST_PULSE: begin
        if (timer_q == PULSE_LAST) state_d = ST_GAP;
        else                       timer_d = timer_q + 1'b1;
      end
      ST_GAP: begin
        if (timer_q == GAP_LAST) state_d = ST_IDLE;
        else                     timer_d = timer_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A lamp falling edge wins over everything; inc and dec together cancel.
  always_comb begin
    pend_d = pend_q;
    if (credit_fall)
      pend_d = 2'd0;
    else if (coin_inc && !pend_dec)
      pend_d = (pend_q >= Q_MAX) ? pend_q : pend_q + 2'd1;
    else if (!coin_inc && pend_dec)
      pend_d = pend_q - 2'd1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      pend_q     <= 2'd0;
      coin_sw_q  <= 1'b0;
      busy_q     <= 1'b0;
      credit_q   <= 1'b0;
      coin_lvl_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pend_q     <= pend_d;
      coin_sw_q  <= (state_d == ST_PULSE);
      busy_q     <= (state_d != ST_IDLE);
      credit_q   <= io.credit_light_n;
      coin_lvl_q <= coin_lvl;
    end
  end

  assign io.coin_sw      = coin_sw_q;
  assign io.busy         = busy_q;
  assign io.coin_pending = pend_q;
  assign io.start_game   = start_lvl;
endmodule

// File: tb/tb_coin_sw_ctrl.sv
// Directed bench for coin_sw_ctrl with short timing constants: a per-cycle
// vector table for start debounce / reset / dropped coins, then coin sequences.
module tb_coin_sw_ctrl;
  localparam int DEB = 4;
  localparam int PUL = 10;
  localparam int GAP = 6;
  localparam int QM  = 3;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;

  coin_sw_ctrl_if io();

  coin_sw_ctrl #(
    .DEBOUNCE_CNT (DEB),
    .PULSE_CNT    (PUL),
    .GAP_CNT      (GAP),
    .QUEUE_MAX    (QM)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .io      (io.slave)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec  = 0;
  int n_fail = 0;

  // pulse monitor state
  int pulses   = 0;
  int hi_run   = 0;
  int lo_run   = 0;
  int max_pend = 0;
  bit seen_pulse = 1'b0;

  bit arm_credit = 1'b0;
  bit fired      = 1'b0;

  typedef struct {
    logic       rst;
    logic       start;
    logic       coin;
    logic       credit;
    logic [4:0] exp;   // {start_game, coin_sw, busy, coin_pending[1:0]}
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (arm_credit && io.coin_sw && io.coin_pending == 2'd2) begin
      io.credit_light_n = 1'b0;
      arm_credit = 1'b0;
      fired = 1'b1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    io.coin_raw = 1'b0;
    io.start_raw = 1'b0;
    io.credit_light_n = 1'b1;
    run(2);
    reset = 1'b0;
    max_pend = 0;
    check("after_reset", int'({io.start_game, io.coin_sw, io.busy, io.coin_pending}), 0);
  endtask

  task automatic press(input int h, input int l);
    io.coin_raw = 1'b1;
    run(h);
    io.coin_raw = 1'b0;
    run(l);
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      tick();
      if (!io.busy && io.coin_pending == 2'd0) break;
    end
    check({name, "_timeout"}, int'(i < budget), 1);
  endtask

  task automatic add(input logic r, input logic s, input logic c, input logic cr,
                     input logic [4:0] e);
    vt.push_back('{rst: r, start: s, coin: c, credit: cr, exp: e});
  endtask

  // Pulse width and inter-pulse gap are checked on every pulse the DUT emits.
  initial forever begin
    @(negedge clk_sys);
    if (reset) begin
      hi_run = 0;
      lo_run = 0;
      seen_pulse = 1'b0;
    end else if (io.coin_sw) begin
      if (hi_run == 0 && seen_pulse) begin
        n_vec++;
        if (lo_run < GAP) begin
          n_fail++;
          $display("FAIL gap_low: got %0d low cycles, need at least %0d", lo_run, GAP);
        end
      end
      hi_run++;
      lo_run = 0;
    end else begin
      if (hi_run != 0) begin
        pulses++;
        seen_pulse = 1'b1;
        n_vec++;
        if (hi_run != PUL) begin
          n_fail++;
          $display("FAIL pulse_width: got %0d expected %0d", hi_run, PUL);
        end
        hi_run = 0;
      end
      lo_run++;
    end
    if (int'(io.coin_pending) > max_pend) max_pend = int'(io.coin_pending);
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    io.coin_raw = 1'b0;
    io.start_raw = 1'b0;
    io.credit_light_n = 1'b1;

    // start debounce: 4 stable synchronised samples -> level moves 6 edges after input
    add(1, 0, 0, 1, 5'b00000);
    add(1, 1, 0, 1, 5'b00000);
    for (int i = 1; i <= 6; i++) add(0, 1, 0, 1, (i == 6) ? 5'b10000 : 5'b00000);
    for (int i = 1; i <= 6; i++) add(0, 0, 0, 1, (i == 6) ? 5'b00000 : 5'b10000);
    // bounce on start never qualifies
    add(0, 1, 0, 1, 5'b00000); add(0, 1, 0, 1, 5'b00000);
    add(0, 0, 0, 1, 5'b00000); add(0, 0, 0, 1, 5'b00000);
    add(0, 1, 0, 1, 5'b00000); add(0, 1, 0, 1, 5'b00000);
    add(0, 1, 0, 1, 5'b00000); add(0, 0, 0, 1, 5'b00000);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 5'b00000);
    // reset clears a high start level; relearns after release
    for (int i = 1; i <= 6; i++) add(0, 1, 0, 1, (i == 6) ? 5'b10000 : 5'b00000);
    add(1, 1, 0, 1, 5'b00000);
    for (int i = 1; i <= 6; i++) add(0, 1, 0, 1, (i == 6) ? 5'b10000 : 5'b00000);
    // coin pressed while credit lamp is lit is dropped
    for (int i = 0; i < 10; i++) add(0, 1, 1, 0, 5'b10000);
    for (int i = 0; i < 8; i++)  add(0, 1, 0, 0, 5'b10000);
    for (int i = 0; i < 4; i++)  add(0, 1, 0, 1, 5'b10000);

    foreach (vt[i]) begin
      reset = vt[i].rst;
      io.start_raw = vt[i].start;
      io.coin_raw = vt[i].coin;
      io.credit_light_n = vt[i].credit;
      tick();
      check($sformatf("vec%0d", i),
            int'({io.start_game, io.coin_sw, io.busy, io.coin_pending}), int'(vt[i].exp));
    end

    // single coin: event at edge 6, pending at 7, pulse begins at edge 8
    do_reset();
    p0 = pulses;
    io.coin_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 7) check("single_e7", int'({io.coin_sw, io.coin_pending}), 1);
      if (i == 8) check("single_e8", int'({io.coin_sw, io.busy, io.coin_pending}), 12);
    end
    io.coin_raw = 1'b0;
    wait_quiet(100, "single");
    run(20);
    check("single_pulses", pulses - p0, 1);
    check("single_pending", int'(io.coin_pending), 0);

    // bounce on coin: toggling every 2 cycles never qualifies
    do_reset();
    p0 = pulses;
    for (int i = 0; i < 20; i++) begin
      io.coin_raw = ((i >> 1) & 1) == 0;
      tick();
    end
    io.coin_raw = 1'b0;
    run(40);
    check("bounce_pulses", pulses - p0, 0);
    check("bounce_maxpend", max_pend, 0);

    // burst: 8 fast presses overflow the 3-deep queue once -> 7 pulses
    do_reset();
    p0 = pulses;
    for (int k = 0; k < 8; k++) press(4, 4);
    wait_quiet(300, "burst");
    run(10);
    check("burst_pulses", pulses - p0, 7);
    check("burst_maxpend", max_pend, QM);
    check("burst_pending", int'(io.coin_pending), 0);

    // credit lamp lit during the second pulse with two coins queued
    do_reset();
    p0 = pulses;
    fired = 1'b0;
    arm_credit = 1'b1;
    for (int k = 0; k < 4; k++) press(4, 4);
    begin
      int i;
      for (i = 0; i < 30; i++) begin
        if (!io.coin_sw) break;
        tick();
      end
      check("credit_pulse_end", int'(i < 30), 1);
    end
    check("credit_fired", int'(fired), 1);
    check("credit_pending", int'(io.coin_pending), 0);
    run(60);
    check("credit_pulses", pulses - p0, 2);
    check("credit_idle", int'({io.coin_sw, io.busy, io.coin_pending}), 0);
    arm_credit = 1'b0;
    io.credit_light_n = 1'b1;

    // reset on PULSE cycle 5
    do_reset();
    p0 = pulses;
    io.coin_raw = 1'b1;
    begin
      int i;
      for (i = 0; i < 30; i++) begin
        tick();
        if (io.coin_sw) break;
      end
      check("rst_pulse_start", int'(i < 30), 1);
    end
    run(4);
    check("rst_in_pulse", int'(io.coin_sw), 1);
    io.coin_raw = 1'b0;
    io.start_raw = 1'b1;
    reset = 1'b1;
    tick();
    check("rst_outputs", int'({io.start_game, io.coin_sw, io.busy, io.coin_pending}), 0);
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("rst_start%0d", i), int'(io.start_game), (i == 6) ? 1 : 0);
    end
    run(30);
    check("rst_no_resume", pulses - p0, 0);
    check("rst_idle", int'({io.coin_sw, io.busy, io.coin_pending}), 0);
    io.start_raw = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
